// File: rtl/dsp_pkg.sv
// Shared DSP constants, register-tag type and the signed saturating narrow
// used by both the MAC and the ALU.
package dsp_pkg;

  localparam int DSP_DATA_W  = 16;
  localparam int DSP_ACC_W   = 40;
  localparam int DSP_Q_SHIFT = 15;

  typedef logic [3:0] reg_tag_t;

  // Clamp a signed value into the range of a signed width-bit number.
  // Only the low width bits of the return value are meaningful to callers.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/dsp_mul_stage.sv
// First MAC pipeline stage: registered full-width signed product plus the
// valid, clear and destination-tag bits that travel with it.
module dsp_mul_stage
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_en,
  input  logic                       clr_acc,
  input  logic [DATA_W-1:0]          op_a,
  input  logic [DATA_W-1:0]          op_b,
  input  reg_tag_t                   rd_in,
  output logic                       valid,
  output logic                       clr,
  output reg_tag_t                   rd,
  output logic signed [2*DATA_W-1:0] prod
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // Widen before multiplying so the product keeps every bit of op_a*op_b.
  assign a_ext = PROD_W'($signed(op_a));
  assign b_ext = PROD_W'($signed(op_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      clr   <= 1'b0;
      rd    <= '0;
      prod  <= '0;
    end else begin
      valid <= mac_en;
      clr   <= clr_acc;
      rd    <= rd_in;
      prod  <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/dsp_mac_unit.sv
// Two-stage signed multiply-accumulate with sticky overflow and Q-format output.
// Build option: define DSP_MAC_SATURATE_EN to clamp the accumulator on overflow.
module dsp_mac_unit
  import dsp_pkg::*;
#(
  parameter int DATA_W    = DSP_DATA_W,
  parameter int ACC_W     = DSP_ACC_W,
  parameter int OUT_SHIFT = DSP_Q_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mac_en,
  input  logic              clr_acc,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  reg_tag_t          rd_in,
  output logic              busy,
  output logic              result_valid,
  output reg_tag_t          result_rd,
  output logic [DATA_W-1:0] result,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic                       s1_valid;
  logic                       s1_clr;
  reg_tag_t                   s1_rd;
  logic signed [2*DATA_W-1:0] s1_prod;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] shifted;
  logic                    add_ovf;
  logic [DATA_W-1:0]       result_next;

  dsp_mul_stage #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .mac_en (mac_en),
    .clr_acc(clr_acc),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .valid  (s1_valid),
    .clr    (s1_clr),
    .rd     (s1_rd),
    .prod   (s1_prod)
  );

  // A clear replaces the base, so a clear+add starts from zero and cannot overflow.
  always_comb begin
    prod_ext = ACC_W'(s1_prod);
    base     = s1_clr ? '0 : acc_r;
    addend   = s1_valid ? prod_ext : '0;
    sum      = base + addend;
    add_ovf  = s1_valid && (base[ACC_W-1] == addend[ACC_W-1])
                        && (sum[ACC_W-1] != base[ACC_W-1]);
    acc_next = sum;
`ifdef DSP_MAC_SATURATE_EN
    if (add_ovf) begin
      acc_next = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    acc_next = sum;
`endif
    shifted     = acc_next >>> OUT_SHIFT;
    result_next = DATA_W'(sat_narrow(64'(shifted), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= '0;
      ovf          <= 1'b0;
      result_valid <= 1'b0;
      result_rd    <= '0;
      result       <= '0;
    end else begin
      acc_r        <= acc_next;
      ovf          <= add_ovf | (ovf & ~s1_clr);
      result_valid <= s1_valid;
      if (s1_valid) begin
        result_rd <= s1_rd;
        result    <= result_next;
      end
    end
  end

  assign acc  = acc_r;
  assign busy = s1_valid | s1_clr | result_valid;

endmodule

// File: tb/tb_dsp_mac_unit.sv
// Directed plus randomized checks of dsp_mac_unit against a timestamped op-queue model.
module tb_dsp_mac_unit;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int OUT_SHIFT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              mac_en;
  logic              clr_acc;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        rd_in;
  logic              busy;
  logic              result_valid;
  logic [3:0]        result_rd;
  logic [DATA_W-1:0] result;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  dsp_mac_unit #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mac_en      (mac_en),
    .clr_acc     (clr_acc),
    .op_a        (op_a),
    .op_b        (op_b),
    .rd_in       (rd_in),
    .busy        (busy),
    .result_valid(result_valid),
    .result_rd   (result_rd),
    .result      (result),
    .acc         (acc),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         done_at;
    bit         en;
    bit         clr;
    longint     a;
    longint     b;
    logic [3:0] rd;
  } op_t;

  op_t    pending[$];
  int     edge_n = 0;
  longint acc_m  = 0;
  bit     ovf_m  = 0;
  bit     exp_valid;
  bit     exp_busy;
  logic [3:0]        exp_rd  = '0;
  logic [DATA_W-1:0] exp_res = '0;

  int checks = 0;
  int errors = 0;

  localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));
  localparam longint DMAX = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint DMIN = -(64'sd1 <<< (DATA_W - 1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic complete(input op_t o);
    longint s;
    longint q;
    if (o.clr) begin
      acc_m = 0;
      ovf_m = 0;
    end
    if (o.en) begin
      s = acc_m + o.a * o.b;
      if (s > AMAX || s < AMIN) begin
        ovf_m = 1;
`ifdef DSP_MAC_SATURATE_EN
        s = (s > AMAX) ? AMAX : AMIN;
`else
        s = (s > AMAX) ? s - (64'sd1 <<< ACC_W) : s + (64'sd1 <<< ACC_W);
`endif
      end
      acc_m = s;
      q = acc_m >>> OUT_SHIFT;
      if (q > DMAX) q = DMAX;
      if (q < DMIN) q = DMIN;
      exp_res   = q[DATA_W-1:0];
      exp_rd    = o.rd;
      exp_valid = 1;
      exp_busy  = 1;
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic step(input bit r, input bit en, input bit clr,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [3:0] rd);
    op_t o;
    rst = r; mac_en = en; clr_acc = clr; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk);
    #1;
    edge_n++;
    exp_valid = 0;
    exp_busy  = 0;
    if (r) begin
      pending.delete();
      acc_m   = 0;
      ovf_m   = 0;
      exp_res = '0;
      exp_rd  = '0;
      chk("rst_result", result, 0);
      chk("rst_result_rd", result_rd, 0);
    end else begin
      while (pending.size() > 0 && pending[0].done_at == edge_n) begin
        complete(pending.pop_front());
      end
      if (en || clr) begin
        o.done_at = edge_n + 1;
        o.en  = en;
        o.clr = clr;
        o.a   = longint'($signed(a));
        o.b   = longint'($signed(b));
        o.rd  = rd;
        pending.push_back(o);
        exp_busy = 1;
      end
    end
    chk("result_valid", result_valid, exp_valid);
    chk("busy", busy, exp_busy);
    chk("acc", acc, acc_m[ACC_W-1:0]);
    chk("ovf", ovf, ovf_m);
    if (exp_valid) begin
      chk("result", result, exp_res);
      chk("result_rd", result_rd, exp_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    rst = 1; mac_en = 0; clr_acc = 0; op_a = '0; op_b = '0; rd_in = '0;

    // Reset held two cycles with issue active; nothing may come out afterwards.
    step(1, 1, 0, 16'd7, 16'd9, 4'd1);
    step(1, 1, 0, 16'd7, 16'd9, 4'd1);
    step(0, 0, 0, '0, '0, '0);
    chk("post_rst_valid", result_valid, 0);
    step(0, 0, 0, '0, '0, '0);
    chk("post_rst_acc", acc, 0);

    // Back-to-back issue.
    step(0, 1, 1, 16'd3, 16'd4, 4'd2);
    step(0, 1, 0, 16'd5, 16'd6, 4'd3);
    chk("b2b_acc0", acc, 32'd12);
    chk("b2b_rd0", result_rd, 4'd2);
    chk("b2b_res0", result, 16'd0);
    step(0, 0, 0, '0, '0, '0);
    chk("b2b_acc1", acc, 32'd42);
    chk("b2b_rd1", result_rd, 4'd3);
    chk("b2b_valid1", result_valid, 1);
    idle(2);

    // Q15 scaling.
    step(0, 1, 1, 16'h4000, 16'h4000, 4'd5);
    step(0, 0, 0, '0, '0, '0);
    chk("q15_acc", acc, 32'h1000_0000);
    chk("q15_res", result, 16'h2000);
    idle(1);

    // Output narrowing saturates without accumulator overflow.
    step(0, 1, 1, 16'h8000, 16'h8000, 4'd6);
    step(0, 0, 0, '0, '0, '0);
    chk("nsat_acc", acc, 32'h4000_0000);
    chk("nsat_res", result, 16'h7FFF);
    chk("nsat_ovf", ovf, 0);

    // Accumulator overflow, sticky flag, then a lone clear.
    step(0, 1, 1, 16'h8000, 16'h8000, 4'd7);
    step(0, 1, 0, 16'h8000, 16'h8000, 4'd8);
    step(0, 0, 0, '0, '0, '0);
`ifdef DSP_MAC_SATURATE_EN
    chk("aovf_acc", acc, 32'h7FFF_FFFF);
`else
    chk("aovf_acc", acc, 32'h8000_0000);
`endif
    chk("aovf_ovf", ovf, 1);
    idle(2);
    chk("aovf_sticky", ovf, 1);
    step(0, 0, 1, '0, '0, '0);
    chk("lone_clr_busy", busy, 1);
    step(0, 0, 0, '0, '0, '0);
    chk("lone_clr_acc", acc, 0);
    chk("lone_clr_ovf", ovf, 0);
    chk("lone_clr_novalid", result_valid, 0);

    // Reset while an op is in flight.
    step(0, 1, 0, 16'd2, 16'd2, 4'd9);
    step(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_busy", busy, 0);

    // Randomized traffic, including occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           DATA_W'($urandom),
           DATA_W'($urandom),
           4'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_mac_unit.md
# dsp_mac_unit

Pipelined signed multiply-accumulate datapath for the DSP core. It sits directly downstream of the control unit and is enabled by its `mac_en` strobe. It consumes the two source-register values selected by `rs`/`rt` and returns a Q15 result tagged with `rd` for register-file writeback. It keeps a wide internal accumulator, accepts one operation per cycle, and flags overflow.

## Interface
- `DATA_W`, default 16: operand and result width (signed two's complement).
- `ACC_W`, default 40: accumulator width; must be ≥ 2*`DATA_W`.
- `OUT_SHIFT`, default 15: arithmetic right shift applied to the accumulator to form `result` (Q15).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mac_en`, input, 1: issue strobe; sampled every cycle.
- `clr_acc`, input, 1: zero the accumulator before this op's add; valid without `mac_en`.
- `op_a`, input, `DATA_W`: signed multiplicand (Rs value).
- `op_b`, input, `DATA_W`: signed multiplier (Rt value).
- `rd_in`, input, 4: destination tag, carried through the pipeline.
- `busy`, output, 1: at least one op is in stage 1 or stage 2.
- `result_valid`, output, 1: one-cycle pulse per completed MAC.
- `result_rd`, output, 4: tag belonging to `result`.
- `result`, output, `DATA_W`: accumulator >>> `OUT_SHIFT`, saturated to `DATA_W`.
- `acc`, output, `ACC_W`: current accumulator.
- `ovf`, output, 1: sticky accumulator-overflow flag.

## Operation
- Stage 1 (S1), on the edge that samples `mac_en` or `clr_acc`:
  - Registers the full signed product `op_a*op_b` (2*`DATA_W` bits).
  - Registers `rd_in`, `clr_acc`, and a valid bit equal to `mac_en`.
- Stage 2 (S2), on the next edge:
  - Base = 0 if S1 clr, otherwise `acc`.
  - If S1 valid: `acc` ← base + sign-extended product. Otherwise `acc` ← base.
  - `result` is formed from the new accumulator value. Narrowing always saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Signed overflow is detected on the add: operands have the same sign and the sum has a different sign.
  - Overflow sets `ovf`.
  - `ovf` is cleared only by `rst` or by a clr reaching S2.
  - When a clr and an overflowing add coincide, the clr applies first, so the add cannot overflow.
- `clr_acc` without `mac_en`:
  - Zeroes `acc` and `ovf` in S2.
  - No `result_valid`.
  - `busy` is high for that op's S1 cycle.
- Back-to-back issue every cycle is supported. Ops complete in issue order with no stalls. There is no backpressure.
- `rst` clears the S1/S2 valid bits, `acc`, `ovf`, and all outputs. In-flight ops are discarded and produce no `result_valid`.

## Timing
- Latency:
  - Op sampled at edge E0.
  - Product registered at E0.
  - Accumulate at E1.
  - `result_valid`, `result`, `result_rd`, and `acc` update visible after E1, i.e. 2 cycles from issue.
- Throughput: 1 op per cycle.
- Reset values: `busy`=0, `result_valid`=0, `result_rd`=0, `result`=0, `acc`=0, `ovf`=0.
- `result_valid` is high for exactly one cycle per op and is never high during or in the cycle after `rst`.
- `busy` = S1 valid OR S1 clr OR S2 valid. It is combinational from the pipeline registers.

## Configuration
- `DSP_MAC_SATURATE_EN`:
  - Defined: on overflow, `acc` clamps to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative); `ovf` is set.
  - Undefined: `acc` wraps modulo 2^ACC_W; `ovf` is still set.
  - `result` narrowing saturation is unaffected by the macro.

## Structure
- Shared package `dsp_pkg`:
  - `DSP_DATA_W`, `DSP_ACC_W`, `DSP_Q_SHIFT` constants.
  - Register-tag type (4-bit).
  - Signed saturating-narrow function, reused by the ALU.
- One sub-module, `dsp_mul_stage`: S1 registered signed multiplier carrying the valid, clr and tag bits. The accumulate stage, overflow logic and output narrowing stay in `dsp_mac_unit`.

## Test plan
- Reset: hold `rst` 2 cycles with `mac_en`=1, then release → all outputs 0, no `result_valid`.
- Back-to-back: `clr_acc`=1 with (3,4, rd=2), then (5,6, rd=3) next cycle → `acc`=12, `result_rd`=2 at issue+2; `acc`=42, `result_rd`=3 one cycle later; `result_valid` high both cycles; `result`=0 both times (small values >>> 15).
- Q15: `clr_acc`+`mac_en`, a=b=0x4000 → `acc`=0x10000000, `result`=0x2000.
- Narrow saturation: `clr_acc`+`mac_en`, a=b=0x8000 → `acc`=0x40000000, `result`=0x7FFF, `ovf`=0.
- Accumulator overflow with `ACC_W`=32: clr op then a second op, both a=b=0x8000 → with macro, `acc`=0x7FFFFFFF; without macro, `acc`=0x80000000; `ovf`=1 in both builds; a following lone `clr_acc` → `acc`=0, `ovf`=0.
- Reset mid-flight: `mac_en` (2,2), then `rst` on the next cycle → no `result_valid`, `acc`=0, `busy`=0.
